uv_nbr_buf: RTL and testbench

Chroma neighbour-edge store for the UV intra-prediction path. Captures reconstructed 8x8 U/V blocks row by row and keeps two edges: the bottom row of every macroblock column in a line buffer, and the right column of the most recent macroblock in a left register. On a fetch it supplies top_u/top_v/left_u/left_v in the packed format the UV predictors consume, with a start/done style handshake.

---
 rtl/uv_nbr_buf_if.sv | 47 ++++
 rtl/uv_nbr_buf.sv | 194 +++++++++++++++++++
 tb/tb_uv_nbr_buf.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uv_nbr_buf_if.sv
// uv_nbr_buf_if
// Bundles the fetch/store handshake, the reconstructed-row input bus and the
// packed neighbour-edge outputs of uv_nbr_buf into one interface.
//
// Signals:
//   fetch, store_start          request strobes (sampled by the buffer in IDLE)
//   x, y                        macroblock column / row
//   rec_valid, rec_row_u/v      one reconstructed chroma row per valid cycle
//   top_u/v, left_u/v           packed edges, sample i in [8i+7:8i]
//   fetch_done, store_done      one-cycle completion pulses
//   busy                        buffer is not idle
//
// Modports:
//   master  the requester / reconstruction side (drives requests and rows)
//   slave   the neighbour buffer itself
interface uv_nbr_buf_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int BLOCK_NUM  = 10
);
    localparam int EDGE_W = BIT_WIDTH * BLOCK_SIZE;

    logic                 fetch;
    logic                 store_start;
    logic [BLOCK_NUM-1:0] x;
    logic [BLOCK_NUM-1:0] y;
    logic                 rec_valid;
    logic [EDGE_W-1:0]    rec_row_u;
    logic [EDGE_W-1:0]    rec_row_v;
    logic [EDGE_W-1:0]    top_u;
    logic [EDGE_W-1:0]    top_v;
    logic [EDGE_W-1:0]    left_u;
    logic [EDGE_W-1:0]    left_v;
    logic                 fetch_done;
    logic                 store_done;
    logic                 busy;

    modport master (
        output fetch, store_start, x, y, rec_valid, rec_row_u, rec_row_v,
        input  top_u, top_v, left_u, left_v, fetch_done, store_done, busy
    );

    modport slave (
        input  fetch, store_start, x, y, rec_valid, rec_row_u, rec_row_v,
        output top_u, top_v, left_u, left_v, fetch_done, store_done, busy
    );
endinterface

// File: rtl/uv_nbr_buf.sv
// uv_nbr_buf
// Chroma neighbour-edge store for UV intra prediction. Reconstructed 8x8 U/V
// blocks arrive row by row; the bottom row of each block is kept in a line
// buffer indexed by macroblock column, and the right column of the most
// recently stored block is kept in the left registers. A fetch returns the
// top edge (line buffer at x) and the left edge in packed predictor format.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    uv_nbr_buf_if.slave: fetch/store_start/x/y/rec_valid/rec_row_u/v
//          in; top_u/v, left_u/v, fetch_done, store_done, busy out
//
// Configuration macro:
//   NBR_ZERO_FILL_EN  when defined, a fetch at y==0 returns a zero top edge
//                     and a fetch at x==0 returns a zero left edge.
module uv_nbr_buf #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int BLOCK_NUM  = 10,
    parameter int MAX_MB_W   = 64
) (
    input logic         clk,
    input logic         rst_n,
    uv_nbr_buf_if.slave bus
);
    localparam int EDGE_W = BIT_WIDTH * BLOCK_SIZE;
    localparam int ADDR_W = $clog2(MAX_MB_W);
    localparam int ROW_W  = $clog2(BLOCK_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        OUT,
        STORE,
        COMMIT
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [BLOCK_NUM-1:0] lx;
    logic [ROW_W-1:0]     row_cnt;
    logic                 last_row;
    logic [EDGE_W-1:0]    left_col_u;
    logic [EDGE_W-1:0]    left_col_v;
    logic [EDGE_W-1:0]    bottom_u;
    logic [EDGE_W-1:0]    bottom_v;
    logic [EDGE_W-1:0]    top_u_q;
    logic [EDGE_W-1:0]    top_v_q;
    logic [EDGE_W-1:0]    left_u_q;
    logic [EDGE_W-1:0]    left_v_q;

    logic [2*EDGE_W-1:0]  line_mem [MAX_MB_W];
    logic [2*EDGE_W-1:0]  rd_word;
    logic [ADDR_W-1:0]    addr;
    logic                 in_range;
    logic                 top_zero;
    logic                 left_zero;

    logic                 busy_c;
    logic                 fetch_done_c;
    logic                 store_done_c;

    // Line-buffer address is the low bits of x; any set upper bit means the
    // column lies beyond the buffer, so reads return zero and writes are dropped.
    assign addr     = lx[ADDR_W-1:0];
    assign in_range = ((lx >> ADDR_W) == '0);
    assign last_row = (row_cnt == ROW_W'(BLOCK_SIZE - 1));
    assign rd_word  = line_mem[addr];

`ifdef NBR_ZERO_FILL_EN
    logic [BLOCK_NUM-1:0] ly;

    // Row coordinate is only needed to blank the top edge on the first
    // macroblock row, so it is latched only in the zero-fill build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ly <= '0;
        end else if (state == IDLE && (bus.fetch || bus.store_start)) begin
            ly <= bus.y;
        end
    end

    assign top_zero  = (ly == '0);
    assign left_zero = (lx == '0);
`else
    assign top_zero  = 1'b0;
    assign left_zero = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; fetch wins over store_start when both arrive in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.fetch) begin
                    state_nxt = RD;
                end else if (bus.store_start) begin
                    state_nxt = STORE;
                end
            end
            RD:      state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            STORE: begin
                if (bus.rec_valid && last_row) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy_c       = (state != IDLE);
        fetch_done_c = (state == OUT);
        store_done_c = (state == COMMIT);
    end

    // Coordinate latch, row capture and edge output registers. The line-buffer
    // read is clocked straight into the top-edge registers at the end of RD so
    // that the edges are already valid during the OUT cycle that pulses
    // fetch_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lx         <= '0;
            row_cnt    <= '0;
            left_col_u <= '0;
            left_col_v <= '0;
            bottom_u   <= '0;
            bottom_v   <= '0;
            top_u_q    <= '0;
            top_v_q    <= '0;
            left_u_q   <= '0;
            left_v_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.fetch) begin
                        lx <= bus.x;
                    end else if (bus.store_start) begin
                        lx      <= bus.x;
                        row_cnt <= '0;
                    end
                end
                RD: begin
                    top_u_q  <= (in_range && !top_zero) ? rd_word[EDGE_W-1:0] : '0;
                    top_v_q  <= (in_range && !top_zero) ? rd_word[2*EDGE_W-1:EDGE_W] : '0;
                    left_u_q <= left_zero ? '0 : left_col_u;
                    left_v_q <= left_zero ? '0 : left_col_v;
                end
                STORE: begin
                    if (bus.rec_valid) begin
                        left_col_u[row_cnt*BIT_WIDTH +: BIT_WIDTH] <= bus.rec_row_u[EDGE_W-1 -: BIT_WIDTH];
                        left_col_v[row_cnt*BIT_WIDTH +: BIT_WIDTH] <= bus.rec_row_v[EDGE_W-1 -: BIT_WIDTH];
                        row_cnt <= row_cnt + 1'b1;
                        if (last_row) begin
                            bottom_u <= bus.rec_row_u;
                            bottom_v <= bus.rec_row_v;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line-buffer write of the captured bottom row; contents are not reset.
    always_ff @(posedge clk) begin
        if (state == COMMIT && in_range) begin
            line_mem[addr] <= {bottom_v, bottom_u};
        end
    end

    assign bus.top_u      = top_u_q;
    assign bus.top_v      = top_v_q;
    assign bus.left_u     = left_u_q;
    assign bus.left_v     = left_v_q;
    assign bus.busy       = busy_c;
    assign bus.fetch_done = fetch_done_c;
    assign bus.store_done = store_done_c;
endmodule

// File: tb/tb_uv_nbr_buf.sv
// tb_uv_nbr_buf
// Scoreboard bench for uv_nbr_buf: stimulus tasks push the expected fetch
// edges / store completion cycles into queues, and a negedge monitor pops
// and compares them whenever fetch_done or store_done is seen.
module tb_uv_nbr_buf;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [63:0] top_u;
        logic [63:0] top_v;
        logic [63:0] left_u;
        logic [63:0] left_v;
        int          cyc;
    } fetch_exp_t;

    fetch_exp_t fetch_q[$];
    int         store_q[$];

    uv_nbr_buf_if bus ();

    uv_nbr_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10 ns clock and a free-running cycle counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something wedges the stimulus.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat_u(input logic [7:0] s, input int r);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[8*c +: 8] = s + 8'(16 * r + c);
        return v;
    endfunction

    function automatic logic [63:0] pat_v(input logic [7:0] s, input int r);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[8*c +: 8] = s + 8'(r);
        return v;
    endfunction

    function automatic logic [63:0] left_of_u(input logic [7:0] s);
        logic [63:0] v;
        for (int r = 0; r < 8; r++) v[8*r +: 8] = s + 8'(16 * r + 7);
        return v;
    endfunction

    function automatic logic [63:0] left_of_v(input logic [7:0] s);
        logic [63:0] v;
        for (int r = 0; r < 8; r++) v[8*r +: 8] = s + 8'(r);
        return v;
    endfunction

    // Monitor: every done pulse must match the head of its queue, including
    // the cycle at which it was predicted.
    always @(negedge clk) begin
        fetch_exp_t e;
        int         sc;
        if (bus.fetch_done === 1'b1) begin
            if (fetch_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_fetch_done: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = fetch_q.pop_front();
                check_output("fetch_done_cycle", 64'(cyc), 64'(e.cyc));
                check_output("top_u", bus.top_u, e.top_u);
                check_output("top_v", bus.top_v, e.top_v);
                check_output("left_u", bus.left_u, e.left_u);
                check_output("left_v", bus.left_v, e.left_v);
            end
        end
        if (bus.store_done === 1'b1) begin
            if (store_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_store_done: got pulse at cycle %0d expected none", cyc);
            end else begin
                sc = store_q.pop_front();
                check_output("store_done_cycle", 64'(cyc), 64'(sc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until the monitor has consumed every expectation.
    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && (fetch_q.size() > 0 || store_q.size() > 0); i++) tick();
        checks++;
        if (fetch_q.size() > 0 || store_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d pending expectations expected 0", name,
                     fetch_q.size() + store_q.size());
            fetch_q.delete();
            store_q.delete();
        end
    endtask

    // Issues a fetch; fetch_done is predicted two cycles after the sampling edge's cycle.
    task automatic do_fetch(input logic [9:0] fx, input logic [9:0] fy,
                            input logic [63:0] tu, input logic [63:0] tv,
                            input logic [63:0] lu, input logic [63:0] lv);
        fetch_exp_t e;
        tick();
        bus.fetch = 1'b1;
        bus.x     = fx;
        bus.y     = fy;
        e.top_u   = tu;
        e.top_v   = tv;
        e.left_u  = lu;
        e.left_v  = lv;
        e.cyc     = cyc + 2;
        fetch_q.push_back(e);
        tick();
        bus.fetch = 1'b0;
        wait_drain("fetch");
    endtask

    // Stores nrows rows of the seeded pattern, optionally with an idle gap
    // carrying junk data before every row after the first.
    task automatic do_store(input logic [9:0] fx, input logic [9:0] fy,
                            input logic [7:0] su, input logic [7:0] sv,
                            input bit gap, input int nrows);
        tick();
        bus.store_start = 1'b1;
        bus.x           = fx;
        bus.y           = fy;
        tick();
        bus.store_start = 1'b0;
        for (int r = 0; r < nrows; r++) begin
            if (gap && r > 0) begin
                bus.rec_valid = 1'b0;
                bus.rec_row_u = 64'hDEAD_BEEF_DEAD_BEEF;
                bus.rec_row_v = 64'hBAD0_BAD0_BAD0_BAD0;
                tick();
            end
            bus.rec_valid = 1'b1;
            bus.rec_row_u = pat_u(su, r);
            bus.rec_row_v = pat_v(sv, r);
            if (r == 7) store_q.push_back(cyc + 1);
            tick();
        end
        bus.rec_valid = 1'b0;
        if (nrows == 8) wait_drain("store");
    endtask

    // Directed scenario sequence.
    task automatic apply_stimulus();
        int busy_cnt;

        // Reset values.
        #3;
        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_fetch_done", 64'(bus.fetch_done), 64'd0);
        check_output("reset_store_done", 64'(bus.store_done), 64'd0);
        check_output("reset_top_u", bus.top_u, 64'd0);
        check_output("reset_left_v", bus.left_v, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: basic store then fetch of the next row.
        $display("[TB] scenario 1: store x=3 y=0, fetch x=3 y=1");
        do_store(10'd3, 10'd0, 8'h00, 8'h80, 1'b0, 8);
        do_fetch(10'd3, 10'd1, 64'h7776757473727170, 64'h8787878787878787,
                 64'h7767574737271707, 64'h8786858483828180);

        // 2: simultaneous fetch and store_start.
        $display("[TB] scenario 2: fetch and store_start together");
        tick();
        bus.fetch       = 1'b1;
        bus.store_start = 1'b1;
        bus.x           = 10'd3;
        bus.y           = 10'd1;
        fetch_q.push_back('{64'h7776757473727170, 64'h8787878787878787,
                            64'h7767574737271707, 64'h8786858483828180, cyc + 2});
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (i == 1) begin
                bus.fetch       = 1'b0;
                bus.store_start = 1'b0;
            end
        end
        check_output("busy_cycles", 64'(busy_cnt), 64'd2);
        wait_drain("fetch_priority");
        do_store(10'd7, 10'd1, 8'h21, 8'h09, 1'b0, 8);

        // 3: rec_valid with gaps.
        $display("[TB] scenario 3: gapped store x=5");
        do_store(10'd5, 10'd0, 8'h11, 8'h30, 1'b1, 8);
        do_fetch(10'd5, 10'd1, pat_u(8'h11, 7), pat_v(8'h30, 7),
                 left_of_u(8'h11), left_of_v(8'h30));

        // 4: reset in the middle of a store.
        $display("[TB] scenario 4: reset after 4 rows");
        do_store(10'd3, 10'd1, 8'h40, 8'h10, 1'b0, 4);
        rst_n = 1'b0;
        #1;
        check_output("midreset_busy", 64'(bus.busy), 64'd0);
        check_output("midreset_store_done", 64'(bus.store_done), 64'd0);
        check_output("midreset_top_u", bus.top_u, 64'd0);
        check_output("midreset_left_u", bus.left_u, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        do_fetch(10'd3, 10'd1, 64'h7776757473727170, 64'h8787878787878787, 64'd0, 64'd0);

        // 5: column beyond the line buffer.
        $display("[TB] scenario 5: out-of-range column");
        do_store(10'd1, 10'd1, 8'h05, 8'h60, 1'b0, 8);
        do_store(10'd65, 10'd1, 8'hA0, 8'h50, 1'b0, 8);
        do_fetch(10'd65, 10'd2, 64'd0, 64'd0, left_of_u(8'hA0), left_of_v(8'h50));
        do_fetch(10'd1, 10'd2, pat_u(8'h05, 7), pat_v(8'h60, 7),
                 left_of_u(8'hA0), left_of_v(8'h50));

        // 6: picture corner.
        $display("[TB] scenario 6: fetch at x=0 y=0");
        do_store(10'd0, 10'd0, 8'h33, 8'h44, 1'b0, 8);
`ifdef NBR_ZERO_FILL_EN
        do_fetch(10'd0, 10'd0, 64'd0, 64'd0, 64'd0, 64'd0);
`else
        do_fetch(10'd0, 10'd0, pat_u(8'h33, 7), pat_v(8'h44, 7),
                 left_of_u(8'h33), left_of_v(8'h44));
`endif
        tick();
        tick();
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.fetch       = 1'b0;
        bus.store_start = 1'b0;
        bus.x           = '0;
        bus.y           = '0;
        bus.rec_valid   = 1'b0;
        bus.rec_row_u   = '0;
        bus.rec_row_v   = '0;
        apply_stimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
